// File: rtl/s32x_sdr_bridge.sv
// Bridges the 32X SDRAM port strobes onto a single-outstanding req/ack memory port.
// A critical-word-first line buffer serves reads; writes go straight through to memory.
module s32x_sdr_bridge #(
    parameter int unsigned LineWords = 8,
    parameter int unsigned MinWait   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] sdr_a_i,
    input  logic [15:0] sdr_di_i,
    output logic [15:0] sdr_do_o,
    input  logic        sdr_cs_i,
    input  logic [1:0]  sdr_we_i,
    input  logic        sdr_rd_i,
    output logic        sdr_wait_o,
    output logic [16:0] mem_a_o,
    output logic [15:0] mem_do_o,
    input  logic [15:0] mem_di_i,
    output logic [1:0]  mem_we_o,
    output logic        mem_rd_o,
    output logic        mem_req_o,
    input  logic        mem_ack_i
);

    localparam int unsigned IdxW  = $clog2(LineWords);
    localparam int unsigned TagW  = 17 - IdxW;
    localparam int unsigned CntW  = $clog2(MinWait);
    localparam int unsigned LeftW = IdxW + 1;

    localparam logic [CntW-1:0]  WaitInit = CntW'(MinWait - 1);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [IdxW-1:0]  IdxOne   = IdxW'(1);
    localparam logic [LeftW-1:0] LeftOne  = LeftW'(1);
    localparam logic [LeftW-1:0] LineCnt  = LeftW'(LineWords);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHit   = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StMiss  = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]                  sh_q, sh_d;
    logic [16:0]                 a_q, a_d;
    logic [15:0]                 di_q, di_d;
    logic [1:0]                  we_q, we_d;
    logic [CntW-1:0]             wait_cnt_q, wait_cnt_d;
    logic                        sdr_wait_q, sdr_wait_d;
    logic [15:0]                 sdr_do_q, sdr_do_d;
    logic [TagW-1:0]             tag_q, tag_d;
    logic [LineWords-1:0]        valid_q, valid_d;
    logic [LineWords-1:0][15:0]  buf_q, buf_d;
    logic                        fill_act_q, fill_act_d;
    logic [IdxW-1:0]             fill_idx_q, fill_idx_d;
    logic [LeftW-1:0]            fill_left_q, fill_left_d;
    logic                        fill_stale_q, fill_stale_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_rd_q, mem_rd_d;
    logic [1:0]                  mem_we_q, mem_we_d;
    logic [16:0]                 mem_a_q, mem_a_d;
    logic [15:0]                 mem_do_q, mem_do_d;

    logic            acc, ack_v, fill_ack, wr_ack, fill_start, in_tag_hit;
    logic [IdxW-1:0] in_idx, cur_idx;
    logic [TagW-1:0] in_tag, cur_tag;

    assign acc        = sdr_cs_i & (sdr_rd_i | (|sdr_we_i));
    assign ack_v      = mem_ack_i & mem_req_q;
    // A stale ack belongs to a fill that was superseded by a new line.
    assign fill_ack   = ack_v & mem_rd_q & ~fill_stale_q;
    assign wr_ack     = ack_v & ~mem_rd_q;
    assign in_idx     = sdr_a_i[IdxW-1:0];
    assign in_tag     = sdr_a_i[16:IdxW];
    assign cur_idx    = a_q[IdxW-1:0];
    assign cur_tag    = a_q[16:IdxW];
    assign in_tag_hit = (in_tag == tag_q);

    always_comb begin
        sh_d         = sh_q;
        a_d          = a_q;
        di_d         = di_q;
        we_d         = we_q;
        wait_cnt_d   = wait_cnt_q;
        sdr_wait_d   = sdr_wait_q;
        sdr_do_d     = sdr_do_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        buf_d        = buf_q;
        fill_act_d   = fill_act_q;
        fill_idx_d   = fill_idx_q;
        fill_left_d  = fill_left_q;
        fill_stale_d = fill_stale_q;
        mem_req_d    = mem_req_q;
        mem_rd_d     = mem_rd_q;
        mem_we_d     = mem_we_q;
        mem_a_d      = mem_a_q;
        mem_do_d     = mem_do_q;
        fill_start   = 1'b0;

        if (ack_v) begin
            mem_req_d = 1'b0;
            mem_rd_d  = 1'b0;
            mem_we_d  = 2'b00;
        end
        if (ack_v && mem_rd_q && fill_stale_q) begin
            fill_stale_d = 1'b0;
        end
        if (fill_ack) begin
            buf_d[fill_idx_q]   = mem_di_i;
            valid_d[fill_idx_q] = 1'b1;
            fill_idx_d          = fill_idx_q + IdxOne;
            fill_left_d         = fill_left_q - LeftOne;
            if (fill_left_q == LeftOne) begin
                fill_act_d = 1'b0;
            end
        end

        if (sh_q != StIdle && wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - CntOne;
        end

        case (sh_q)
            StIdle: begin
                if (acc) begin
                    a_d        = sdr_a_i;
                    di_d       = sdr_di_i;
                    we_d       = sdr_we_i;
                    sdr_wait_d = 1'b1;
                    wait_cnt_d = WaitInit;
                    if (|sdr_we_i) begin
                        sh_d = StWrite;
                    end else if (in_tag_hit && valid_q[in_idx]) begin
                        sh_d = StHit;
                    end else if (in_tag_hit && fill_act_q) begin
                        sh_d = StMiss;
                    end else begin
                        sh_d         = StMiss;
                        fill_start   = 1'b1;
                        tag_d        = in_tag;
                        valid_d      = '0;
                        fill_act_d   = 1'b1;
                        fill_idx_d   = in_idx;
                        fill_left_d  = LineCnt;
                        fill_stale_d = mem_req_q & mem_rd_q & ~ack_v;
                    end
                end
            end
            StHit: begin
                sdr_do_d = buf_q[cur_idx];
                sh_d     = StHold;
            end
            StMiss: begin
                if (fill_ack && fill_idx_q == cur_idx) begin
                    sdr_do_d = mem_di_i;
                    sh_d     = StHold;
                end else if (valid_q[cur_idx]) begin
                    sdr_do_d = buf_q[cur_idx];
                    sh_d     = StHold;
                end
            end
            StWrite: begin
                if (wr_ack) begin
                    if (cur_tag == tag_q && valid_q[cur_idx]) begin
                        if (we_q[1]) buf_d[cur_idx][15:8] = di_q[15:8];
                        if (we_q[0]) buf_d[cur_idx][7:0]  = di_q[7:0];
                    end
                    sh_d = StHold;
                end else if (!mem_req_q && !fill_act_q) begin
                    mem_req_d = 1'b1;
                    mem_rd_d  = 1'b0;
                    mem_we_d  = we_q;
                    mem_a_d   = a_q;
                    mem_do_d  = di_q;
                end
            end
            StHold: begin
                if (wait_cnt_q == '0) begin
                    sdr_wait_d = 1'b0;
                    sh_d       = StDone;
                end
            end
            StDone: begin
                if (!acc) sh_d = StIdle;
            end
            default: sh_d = StIdle;
        endcase

        // A freshly started fill issues its first word on the following cycle.
        if (fill_act_q && !mem_req_q && !fill_start) begin
            mem_req_d = 1'b1;
            mem_rd_d  = 1'b1;
            mem_we_d  = 2'b00;
            mem_a_d   = {tag_q, fill_idx_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q         <= StIdle;
            a_q          <= '0;
            di_q         <= '0;
            we_q         <= '0;
            wait_cnt_q   <= '0;
            sdr_wait_q   <= 1'b0;
            sdr_do_q     <= '0;
            tag_q        <= '0;
            valid_q      <= '0;
            buf_q        <= '0;
            fill_act_q   <= 1'b0;
            fill_idx_q   <= '0;
            fill_left_q  <= '0;
            fill_stale_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_a_q      <= '0;
            mem_do_q     <= '0;
        end else begin
            sh_q         <= sh_d;
            a_q          <= a_d;
            di_q         <= di_d;
            we_q         <= we_d;
            wait_cnt_q   <= wait_cnt_d;
            sdr_wait_q   <= sdr_wait_d;
            sdr_do_q     <= sdr_do_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            buf_q        <= buf_d;
            fill_act_q   <= fill_act_d;
            fill_idx_q   <= fill_idx_d;
            fill_left_q  <= fill_left_d;
            fill_stale_q <= fill_stale_d;
            mem_req_q    <= mem_req_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            mem_a_q      <= mem_a_d;
            mem_do_q     <= mem_do_d;
        end
    end

    assign sdr_do_o   = sdr_do_q;
    assign sdr_wait_o = sdr_wait_q;
    assign mem_a_o    = mem_a_q;
    assign mem_do_o   = mem_do_q;
    assign mem_we_o   = mem_we_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_req_o  = mem_req_q;

endmodule

// File: tb/tb_s32x_sdr_bridge.sv
// Bench for s32x_sdr_bridge: directed 32X accesses against a line-level model and a
// latency-3 memory responder.
module tb_s32x_sdr_bridge;

    localparam int LW     = 8;
    localparam int MinW   = 4;
    localparam int MemLat = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [16:0] sdr_a_i = '0;
    logic [15:0] sdr_di_i = '0;
    logic [15:0] sdr_do_o;
    logic        sdr_cs_i = 1'b0;
    logic [1:0]  sdr_we_i = '0;
    logic        sdr_rd_i = 1'b0;
    logic        sdr_wait_o;
    logic [16:0] mem_a_o;
    logic [15:0] mem_do_o;
    logic [15:0] mem_di_i = '0;
    logic [1:0]  mem_we_o;
    logic        mem_rd_o;
    logic        mem_req_o;
    logic        mem_ack_i = 1'b0;

    s32x_sdr_bridge #(.LineWords(LW), .MinWait(MinW)) dut (
        .clk(clk), .rst_n(rst_n),
        .sdr_a_i(sdr_a_i), .sdr_di_i(sdr_di_i), .sdr_do_o(sdr_do_o), .sdr_cs_i(sdr_cs_i),
        .sdr_we_i(sdr_we_i), .sdr_rd_i(sdr_rd_i), .sdr_wait_o(sdr_wait_o),
        .mem_a_o(mem_a_o), .mem_do_o(mem_do_o), .mem_di_i(mem_di_i), .mem_we_o(mem_we_o),
        .mem_rd_o(mem_rd_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Memory contents seen by the responder, and the reference the model reads from.
    logic [15:0] dev_mem [int];
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] init_val(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b, ~b};
    endfunction

    function automatic logic [15:0] dev_rd(input int a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Model state
    int          exp_q[$];
    int          addr_log[$];
    int          model_line = -1;
    int          fill_pos = 0;
    logic [16:0] acc_addr = '0;
    logic        acc_read = 1'b0;
    logic [16:0] exp_wr_a = '0;
    logic [1:0]  exp_wr_we = '0;
    logic [15:0] exp_wr_do = '0;
    logic [15:0] exp_do = '0;
    int          n_reads = 0, n_req = 0, falls = 0, rises = 0, last_wlen = 0, reads_at_fall = 0;

    // Memory responder
    initial begin
        int lat;
        logic [15:0] old;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (!rst_n) begin
                lat = 0;
            end else if (mem_req_o) begin
                lat++;
                if (lat >= MemLat) begin
                    lat = 0;
                    mem_ack_i = 1'b1;
                    if (mem_rd_o) begin
                        mem_di_i = dev_rd(int'(mem_a_o));
                    end else begin
                        old = dev_rd(int'(mem_a_o));
                        dev_mem[int'(mem_a_o)] = {mem_we_o[1] ? mem_do_o[15:8] : old[15:8],
                                                  mem_we_o[0] ? mem_do_o[7:0] : old[7:0]};
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model
    logic prev_wait = 1'b0, prev_req = 1'b0;
    int   wait_len = 0, low_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
            prev_req  = 1'b0;
            wait_len  = 0;
            low_len   = 0;
        end else begin
            if (mem_req_o && !prev_req) begin
                n_req++;
                if (mem_rd_o) begin
                    n_reads++;
                    addr_log.push_back(int'(mem_a_o));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL fill_unexpected: got read at %0h want no read", mem_a_o);
                    end else begin
                        check("fill_addr", 32'(mem_a_o), 32'(exp_q.pop_front()));
                    end
                    if (fill_pos > 0) check("fill_gap", 32'(low_len), 32'd1);
                    fill_pos++;
                end else begin
                    check("wr_addr", 32'(mem_a_o), 32'(exp_wr_a));
                    check("wr_we", 32'(mem_we_o), 32'(exp_wr_we));
                    check("wr_data", 32'(mem_do_o), 32'(exp_wr_do));
                end
            end
            low_len = mem_req_o ? 0 : low_len + 1;
            if (sdr_wait_o && !prev_wait) rises++;
            if (sdr_wait_o) begin
                wait_len++;
            end else if (prev_wait) begin
                falls++;
                last_wlen     = wait_len;
                reads_at_fall = n_reads;
                check("wait_min", (wait_len >= MinW) ? 32'd1 : 32'd0, 32'd1);
                if (acc_read) begin
                    exp_do = ref_rd(int'(acc_addr));
                    check("rd_data", 32'(sdr_do_o), 32'(exp_do));
                end
                wait_len = 0;
            end else begin
                check("do_stable", 32'(sdr_do_o), 32'(exp_do));
            end
            prev_wait = sdr_wait_o;
            prev_req  = mem_req_o;
        end
    end

    task automatic expect_fill(input logic [16:0] a);
        int line;
        line = int'(a) & ~(LW - 1);
        model_line = line;
        fill_pos = 0;
        for (int i = 0; i < LW; i++) exp_q.push_back(line + ((int'(a) + i) % LW));
    endtask

    task automatic access(input logic [16:0] a, input logic wr, input logic [1:0] we,
                          input logic [15:0] di, input int hold);
        int f0;
        logic [15:0] old;
        acc_addr = a;
        acc_read = !wr;
        if (wr) begin
            exp_wr_a  = a;
            exp_wr_we = we;
            exp_wr_do = di;
            old = ref_rd(int'(a));
            ref_mem[int'(a)] = {we[1] ? di[15:8] : old[15:8], we[0] ? di[7:0] : old[7:0]};
        end else if ((int'(a) & ~(LW - 1)) != model_line) begin
            expect_fill(a);
        end
        @(posedge clk);
        #1;
        sdr_a_i  = a;
        sdr_di_i = di;
        sdr_we_i = wr ? we : 2'b00;
        sdr_rd_i = !wr;
        sdr_cs_i = 1'b1;
        f0 = falls;
        for (int c = 0; c < 400 && falls == f0; c++) @(posedge clk);
        checks++;
        if (falls == f0) begin
            errs++;
            $display("FAIL access_timeout: got no SDR_WAIT fall want a fall for addr %0h", a);
        end
        repeat (hold) @(posedge clk);
        #1;
        sdr_cs_i = 1'b0;
        sdr_rd_i = 1'b0;
        sdr_we_i = 2'b00;
    endtask

    task automatic wait_fill();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || mem_req_o) && c < 600) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || mem_req_o) begin
            errs++;
            $display("FAIL fill_timeout: got %0d words pending want 0", exp_q.size());
        end
    endtask

    initial begin
        int r0, q0, w0, li;
        int lit[8];
        lit = '{'h13, 'h14, 'h15, 'h16, 'h17, 'h10, 'h11, 'h12};
        ref_mem[32'h14] = 16'h1234;
        dev_mem[32'h14] = 16'h1234;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 32'(sdr_wait_o), 32'd0);
        check("rst_do", 32'(sdr_do_o), 32'd0);
        check("rst_mem_a", 32'(mem_a_o), 32'd0);
        check("rst_mem_do", 32'(mem_do_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_rd", 32'(mem_rd_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        rst_n = 1'b1;

        // Read miss at 0x13, then 0x11 while the fill is still running
        r0 = n_reads;
        li = addr_log.size();
        access(17'h00013, 1'b0, 2'b00, 16'h0, 0);
        check("miss13_do", 32'(sdr_do_o), 32'h13EC);
        access(17'h00011, 1'b0, 2'b00, 16'h0, 0);
        check("miss11_do", 32'(sdr_do_o), 32'h11EE);
        check("miss11_after_word", (reads_at_fall - r0 >= 7) ? 32'd1 : 32'd0, 32'd1);
        wait_fill();
        check("miss_total_reads", 32'(n_reads - r0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (li + i < addr_log.size()) check("miss_seq", 32'(addr_log[li + i]), 32'(lit[i]));
            else check("miss_seq_short", 32'(addr_log.size() - li), 32'd8);
        end

        // Hit
        q0 = n_req;
        access(17'h00016, 1'b0, 2'b00, 16'h0, 0);
        check("hit16_do", 32'(sdr_do_o), 32'h16E9);
        check("hit16_req", 32'(n_req - q0), 32'd0);
        check("hit16_wait", 32'(last_wlen), 32'd4);

        // Write-through with merge into the valid line
        access(17'h00014, 1'b1, 2'b10, 16'hABCD, 0);
        q0 = n_req;
        access(17'h00014, 1'b0, 2'b00, 16'h0, 0);
        check("rmw14_do", 32'(sdr_do_o), 32'hAB34);
        check("rmw14_req", 32'(n_req - q0), 32'd0);

        // ACC held after completion must not retrigger
        q0 = n_req;
        w0 = rises;
        access(17'h00015, 1'b0, 2'b00, 16'h0, 10);
        check("hold_req", 32'(n_req - q0), 32'd0);
        check("hold_rises", 32'(rises - w0), 32'd1);
        access(17'h00015, 1'b0, 2'b00, 16'h0, 0);
        check("reaccept_rises", 32'(rises - w0), 32'd2);
        check("reaccept_do", 32'(sdr_do_o), 32'h15EA);

        // Write outside the buffered line, then read it back through a new fill
        access(17'h00123, 1'b1, 2'b11, 16'h5555, 0);
        access(17'h00123, 1'b0, 2'b00, 16'h0, 0);
        check("other_line_do", 32'(sdr_do_o), 32'h5555);
        wait_fill();

        // Reset in the middle of a fill
        acc_addr = 17'h00040;
        acc_read = 1'b1;
        expect_fill(17'h00040);
        r0 = n_reads;
        @(posedge clk);
        #1;
        sdr_a_i  = 17'h00040;
        sdr_rd_i = 1'b1;
        sdr_cs_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            if (n_reads - r0 >= 3 && mem_req_o) break;
        end
        @(negedge clk);
        #2;
        check("rst_mid_pre_req", 32'(mem_req_o), 32'd1);
        rst_n    = 1'b0;
        sdr_cs_i = 1'b0;
        sdr_rd_i = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req_o), 32'd0);
        check("rst_mid_wait", 32'(sdr_wait_o), 32'd0);
        check("rst_mid_do", 32'(sdr_do_o), 32'd0);
        check("rst_mid_mem_a", 32'(mem_a_o), 32'd0);
        check("rst_mid_mem_rd", 32'(mem_rd_o), 32'd0);
        exp_q.delete();
        model_line = -1;
        exp_do = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        r0 = n_reads;
        access(17'h00040, 1'b0, 2'b00, 16'h0, 0);
        check("post_rst_do", 32'(sdr_do_o), 32'h40BF);
        wait_fill();
        check("post_rst_reads", 32'(n_reads - r0), 32'd8);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1);
    end

endmodule
